// File: rtl/cp0.sv
// Coprocessor 0 for the five-stage MIPS core: SR, Cause, EPC and PRId, plus the
// combinational exception/interrupt request that clears the pipeline.
module cp0 #(
   parameter int          EXCCODE_SIZE = 5,
   parameter logic [31:0] PRID         = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [4:0]              CP0_addr,
   input  logic [31:0]             CP0_in,
   input  logic [31:0]             M_PC,
   input  logic                    M_BD,
   input  logic [EXCCODE_SIZE-1:0] M_ExcCode,
   input  logic [5:0]              HWInt,
   input  logic                    EXL_clr,
   output logic [31:0]             CP0_out,
   output logic [31:0]             EPC_out,
   output logic                    req
);

   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] epc;

   logic        int_req;
   logic        exc_req;
   logic [4:0]  code_ext;
   logic [31:0] victim_pc;

   always_comb begin
      int_req   = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
      exc_req   = (M_ExcCode != '0) & ~sr_exl;
      req       = reset & (int_req | exc_req);
      code_ext  = 5'(M_ExcCode);
      victim_pc = M_BD ? (M_PC - 32'd4) : M_PC;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_im     <= '0;
         sr_exl    <= 1'b0;
         sr_ie     <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ip  <= '0;
         cause_exc <= '0;
         epc       <= '0;
      end else begin
         cause_ip <= HWInt;
         if (req) begin
            sr_exl    <= 1'b1;
            cause_bd  <= M_BD;
            cause_exc <= int_req ? 5'd0 : code_ext;
            epc       <= {victim_pc[31:2], 2'b00};
         end else begin
            if (en && CP0_addr == 5'd12) begin
               sr_im  <= CP0_in[15:10];
               sr_exl <= CP0_in[1];
               sr_ie  <= CP0_in[0];
            end
            if (en && CP0_addr == 5'd14) begin
               epc <= CP0_in;
            end
            // eret clears EXL last so it beats a same-cycle mtc0 to SR on that bit
            if (EXL_clr) begin
               sr_exl <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      CP0_out = '0;
      case (CP0_addr)
         5'd12:   CP0_out = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
         5'd13:   CP0_out = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b00};
         5'd14:   CP0_out = epc;
         5'd15:   CP0_out = PRID;
         default: CP0_out = '0;
      endcase
   end

   assign EPC_out = epc;

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios followed by randomized traffic
// compared against a register-word reference model.
module tb_cp0;

   localparam logic [31:0] TB_PRID = 32'h0001_8C01;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [4:0]  CP0_addr;
   logic [31:0] CP0_in;
   logic [31:0] M_PC;
   logic        M_BD;
   logic [4:0]  M_ExcCode;
   logic [5:0]  HWInt;
   logic        EXL_clr;
   logic [31:0] CP0_out;
   logic [31:0] EPC_out;
   logic        req;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_sr, m_cause, m_epc;

   cp0 #(.EXCCODE_SIZE(5), .PRID(TB_PRID)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .CP0_addr  (CP0_addr),
      .CP0_in    (CP0_in),
      .M_PC      (M_PC),
      .M_BD      (M_BD),
      .M_ExcCode (M_ExcCode),
      .HWInt     (HWInt),
      .EXL_clr   (EXL_clr),
      .CP0_out   (CP0_out),
      .EPC_out   (EPC_out),
      .req       (req)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_int();
      bit masked_pending = (HWInt & m_sr[15:10]) != 6'd0;
      return masked_pending && m_sr[0] && !m_sr[1];
   endfunction

   function automatic bit m_req();
      return m_int() || (M_ExcCode != 5'd0 && !m_sr[1]);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return TB_PRID;
         default: return 32'd0;
      endcase
   endfunction

   // Set up one M-stage cycle and check the combinational outputs before the edge.
   task automatic drive(input logic e, input logic [4:0] a, input logic [31:0] din,
                        input logic [31:0] pc, input logic bd, input logic [4:0] code,
                        input logic [5:0] hw, input logic clr);
      en = e; CP0_addr = a; CP0_in = din; M_PC = pc; M_BD = bd;
      M_ExcCode = code; HWInt = hw; EXL_clr = clr;
      #1;
      check("req", {31'd0, req}, {31'd0, m_req()});
      check("cp0_out", CP0_out, m_read(a));
      check("epc_out", EPC_out, m_epc);
   endtask

   task automatic tick();
      bit          r  = m_req();
      bit          ir = m_int();
      logic [31:0] vpc;
      @(posedge clk);
      m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
      if (r) begin
         m_sr    = m_sr | 32'h2;
         m_cause = (m_cause & ~32'h8000_007C) | ({31'd0, M_BD} << 31)
                   | ({27'd0, (ir ? 5'd0 : M_ExcCode)} << 2);
         vpc     = M_BD ? M_PC - 32'd4 : M_PC;
         m_epc   = vpc & ~32'h3;
      end else begin
         if (en && CP0_addr == 5'd12) m_sr = CP0_in & 32'h0000_FC03;
         if (en && CP0_addr == 5'd14) m_epc = CP0_in;
         if (EXL_clr) m_sr = m_sr & ~32'h2;
      end
      #1;
   endtask

   task automatic reset_pulse();
      M_ExcCode = 5'd4;
      #3 reset = 1'b0;
      #1;
      check("rst_req", {31'd0, req}, 32'd0);
      check("rst_epc", EPC_out, 32'd0);
      CP0_addr = 5'd12; #1;
      check("rst_sr", CP0_out, 32'd0);
      CP0_addr = 5'd13; #1;
      check("rst_cause", CP0_out, 32'd0);
      CP0_addr = 5'd15; #1;
      check("rst_prid", CP0_out, TB_PRID);
      m_sr = '0; m_cause = '0; m_epc = '0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      logic [4:0]  ra;
      logic [4:0]  rc;
      logic [31:0] rd;
      reset = 1'b1; en = 0; CP0_addr = 0; CP0_in = 0; M_PC = 0; M_BD = 0;
      M_ExcCode = 0; HWInt = 0; EXL_clr = 0;
      m_sr = '0; m_cause = '0; m_epc = '0;
      #2;
      reset_pulse();

      // exception entry
      drive(0, 5'd0, 0, 32'h3010, 0, 5'd10, 6'd0, 0);
      check("exc_req", {31'd0, req}, 32'd1);
      tick();
      drive(0, 5'd13, 0, 32'h0, 0, 5'd0, 6'd0, 0);
      check("exc_cause", CP0_out, 32'h0000_0028);
      check("exc_epc", EPC_out, 32'h3010);
      check("exc_req_after", {31'd0, req}, 32'd0);
      tick();
      drive(0, 5'd12, 0, 32'h0, 0, 5'd3, 6'd0, 0);
      check("exc_sr", CP0_out, 32'h0000_0002);
      check("exl_blocks", {31'd0, req}, 32'd0);
      tick();
      drive(0, 5'd0, 0, 0, 0, 5'd0, 6'd0, 1); tick();

      // delay-slot exception
      drive(0, 5'd13, 0, 32'h3024, 1, 5'd4, 6'd0, 0);
      check("bd_req", {31'd0, req}, 32'd1);
      tick();
      drive(0, 5'd13, 0, 32'h0, 0, 5'd0, 6'd0, 0);
      check("bd_cause", CP0_out, 32'h8000_0010);
      check("bd_epc", EPC_out, 32'h3020);
      tick();
      drive(0, 5'd0, 0, 0, 0, 5'd0, 6'd0, 1); tick();

      // interrupt, with a same-cycle exception that must lose
      drive(1, 5'd12, 32'h0000_0401, 0, 0, 5'd0, 6'd0, 0); tick();
      drive(0, 5'd13, 0, 0, 0, 5'd0, 6'b000010, 0);
      check("masked_int", {31'd0, req}, 32'd0);
      tick();
      drive(0, 5'd13, 0, 32'h3100, 0, 5'd7, 6'b000001, 0);
      check("int_req", {31'd0, req}, 32'd1);
      tick();
      drive(0, 5'd13, 0, 0, 0, 5'd0, 6'b000001, 0);
      check("int_cause", CP0_out, 32'h0000_0400);
      check("int_epc", EPC_out, 32'h3100);
      check("int_in_handler", {31'd0, req}, 32'd0);
      tick();
      drive(0, 5'd0, 0, 0, 0, 5'd0, 6'd0, 1); tick();

      // exception with same-cycle mtc0 to EPC, then eret colliding with an exception
      drive(1, 5'd14, 32'h0000_DEAD, 32'h4000, 0, 5'd12, 6'd0, 0); tick();
      check("req_drops_mtc0", EPC_out, 32'h4000);
      drive(0, 5'd0, 0, 0, 0, 5'd0, 6'd0, 1); tick();
      drive(0, 5'd12, 0, 32'h5000, 0, 5'd5, 6'd0, 1);
      check("req_vs_eret", {31'd0, req}, 32'd1);
      tick();
      drive(0, 5'd12, 0, 0, 0, 5'd0, 6'd0, 0);
      check("exl_kept", CP0_out & 32'h2, 32'h2);
      tick();

      // eret with a pending enabled interrupt
      drive(1, 5'd12, 32'h0000_0403, 0, 0, 5'd0, 6'b000001, 0); tick();
      drive(0, 5'd12, 0, 0, 0, 5'd0, 6'b000001, 1);
      check("eret_sr_before", CP0_out, 32'h0000_0403);
      tick();
      drive(0, 5'd12, 0, 32'h6000, 0, 5'd0, 6'b000001, 0);
      check("eret_sr_after", CP0_out, 32'h0000_0401);
      check("eret_then_int", {31'd0, req}, 32'd1);
      tick();

      reset_pulse();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 4))
            0: ra = 5'd12;
            1: ra = 5'd13;
            2: ra = 5'd14;
            3: ra = 5'd15;
            default: ra = 5'($urandom);
         endcase
         rc = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
         rd = $urandom;
         if (ra == 5'd12 && $urandom_range(0, 1) == 1) rd[0] = 1'b1;
         drive(($urandom_range(0, 2) == 0), ra, rd, $urandom, 1'($urandom),
               rc, 6'($urandom), ($urandom_range(0, 5) == 0));
         tick();
         if (i % 100 == 99) reset_pulse();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
